mult_sequencer: RTL and testbench

Control FSM for the sum-and-shift multiplier datapath. It sequences the multiplier shift register (parallel load, then serial shift), the accumulator clear and load, and the adder operand select. It iterates once per multiplier bit and reports completion through a four-phase START/DONE handshake. It sits between the top-level multiplier wrapper and its shifter, accumulator and adder. It holds no datapath bits itself.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/iter_counter.sv | 37 +++
 rtl/mult_sequencer.sv | 90 +++++++++
 tb/tb_mult_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg : shared types and constants for the sum-and-shift multiplier
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ADD    = 3'd2,
    SHIFT  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic MODE_SERIAL   = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;

  // Width of an iteration counter reaching tamano-1; never narrower than 1 bit.
  function automatic int cnt_width(input int tamano);
    return (tamano <= 2) ? 1 : $clog2(tamano);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_counter.sv
// ---------------------------------------------------------------------------
// iter_counter : up-counter with sync clear, enable and terminal-count flag
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iter_counter
  import mult_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = (r_cnt == W'(MAX - 1));
  assign o_tc = w_tc;

  // Holds at terminal count so the value survives through FINISH.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer : control FSM for the sum-and-shift multiplier datapath
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_sequencer
  import mult_pkg::*;
#(
  parameter int tamano = 8
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic START,
  input  logic q_lsb,
  output logic shift_mode,
  output logic shift_enable,
  output logic acc_clear,
  output logic acc_load,
  output logic add_sel,
  output logic busy,
  output logic DONE
);

  state_t r_state;
  state_t w_next;
  logic   w_tc;

  iter_counter #(
    .MAX (tamano),
    .W   (cnt_width(tamano))
  ) u_iter_counter (
    .clk     (CLOCK),
    .rst     (RESET),
    .i_clear (r_state == INIT),
    .i_en    (r_state == SHIFT),
    .o_tc    (w_tc)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    shift_mode   = MODE_SERIAL;
    shift_enable = 1'b0;
    acc_clear    = 1'b0;
    acc_load     = 1'b0;
    add_sel      = 1'b0;
    busy         = 1'b1;
    DONE         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (START) w_next = INIT;
      end
      INIT: begin
        shift_mode   = MODE_PARALLEL;
        shift_enable = 1'b1;
        acc_clear    = 1'b1;
        w_next       = ADD;
      end
      ADD: begin
        acc_load = 1'b1;
        add_sel  = q_lsb;
        w_next   = SHIFT;
      end
      SHIFT: begin
        shift_enable = 1'b1;
        w_next       = w_tc ? FINISH : ADD;
      end
      FINISH: begin
        DONE = 1'b1;
        if (!START) w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_sequencer : directed bench with a behavioural datapath and scoreboard
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_sequencer;

  localparam int TAMANO = 8;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic START = 1'b0;
  logic q_lsb;
  logic shift_mode, shift_enable, acc_clear, acc_load, add_sel, busy, DONE;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  r_mcand  = '0;
  logic [7:0]  r_mplier = '0;
  logic [7:0]  r_q      = '0;
  logic [15:0] r_acc    = '0;
  int          r_iter   = 0;
  int          r_loads  = 0;
  int          r_shifts = 0;
  int          r_ones   = 0;

  logic [15:0] exp_q[$];

  always #5 CLOCK = ~CLOCK;

  mult_sequencer #(.tamano(TAMANO)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .START        (START),
    .q_lsb        (q_lsb),
    .shift_mode   (shift_mode),
    .shift_enable (shift_enable),
    .acc_clear    (acc_clear),
    .acc_load     (acc_load),
    .add_sel      (add_sel),
    .busy         (busy),
    .DONE         (DONE)
  );

  assign q_lsb = r_q[0];

  // Shifter + accumulator model: partial product weighted by iteration index.
  always @(posedge CLOCK) begin
    if (shift_enable) begin
      r_shifts <= r_shifts + 1;
      if (shift_mode) r_q <= r_mplier;
      else            r_q <= r_q >> 1;
    end
    if (acc_clear) begin
      r_acc  <= '0;
      r_iter <= 0;
    end else if (acc_load) begin
      r_acc   <= r_acc + (add_sel ? (16'(r_mcand) << r_iter) : 16'd0);
      r_iter  <= r_iter + 1;
      r_loads <= r_loads + 1;
      if (add_sel) r_ones <= r_ones + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {shift_mode, shift_enable, acc_clear, acc_load, add_sel, busy, DONE};
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // One full operation; glitch_at drops START for one cycle after that edge.
  task automatic run(input logic [7:0] mc, input logic [7:0] mp,
                     input int exp_ones, input int glitch_at, input int hold);
    int k;
    int l0, s0, o0;
    logic [15:0] e;
    @(negedge CLOCK);
    r_mcand  = mc;
    r_mplier = mp;
    START    = 1'b1;
    exp_q.push_back(16'(mc) * 16'(mp));
    l0 = r_loads; s0 = r_shifts; o0 = r_ones;
    k = -1;
    while (k < 40) begin
      step();
      k++;
      if (k == 0) chk("init_outs", 32'(outs()), 32'b1110010);
      if (k == 1) chk("add_load", 32'(acc_load), 32'd1);
      if (k == 16) chk("done_early", 32'(DONE), 32'd0);
      if (k == glitch_at) START = 1'b0;
      if (k == glitch_at + 1) START = 1'b1;
      if (DONE) break;
    end
    chk("done_edge", 32'(k), 32'd17);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("product", 32'(r_acc), 32'(e));
    end
    chk("loads", 32'(r_loads - l0), 32'd8);
    chk("shifts", 32'(r_shifts - s0), 32'd9);
    chk("sel_ones", 32'(r_ones - o0), 32'(exp_ones));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("done_hold", 32'({DONE, busy}), 32'b11);
    end
    START = 1'b0;
    step();
    chk("done_fall", 32'({DONE, busy}), 32'b00);
  endtask

  initial begin
    // Reset with START asserted: reset wins.
    RESET = 1'b1;
    START = 1'b1;
    step();
    chk("rst_outs0", 32'(outs()), 32'd0);
    step();
    chk("rst_outs1", 32'(outs()), 32'd0);
    RESET = 1'b0;
    START = 1'b0;
    step();
    chk("post_rst_idle0", 32'(busy), 32'd0);
    step();
    chk("post_rst_idle1", 32'(busy), 32'd0);

    run(8'd13, 8'd11, 3, -1, 5);
    run(8'd200, 8'd0, 0, -1, 0);
    run(8'd255, 8'd255, 8, -1, 1);

    // Abort at E6 (ADD, iteration 2).
    @(negedge CLOCK);
    r_mcand  = 8'd5;
    r_mplier = 8'd3;
    START    = 1'b1;
    for (int k = 0; k <= 5; k++) step();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    RESET = 1'b1;
    step();
    chk("abort_outs", 32'(outs()), 32'd0);
    RESET = 1'b0;
    START = 1'b0;
    step();
    chk("abort_idle", 32'(busy), 32'd0);
    run(8'd7, 8'd9, 2, -1, 0);

    // START glitch during iteration 3 is ignored.
    run(8'd21, 8'd173, 5, 6, 0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
